fpmult_arbiter: RTL and testbench

Round-robin arbiter that shares one `fpmult` single-precision multiplier between `NREQ` requesters in the DSP section of the synth. It latches the winning requester's operands and runs the multiplier through its reset/done protocol. It then returns the product to the granted requester as a one-cycle valid pulse. A watchdog recovers the shared unit if `done` never arrives.

---
 rtl/fpmult_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 41 ++++
 rtl/fpmult_arbiter.sv | 133 +++++++++++++
 tb/tb_fpmult_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmult_arb_pkg.sv
// Shared definitions for the fpmult round-robin arbiter.
package fpmult_arb_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } state_t;

  // Watchdog counter width: must be able to hold the value TIMEOUT itself.
  function automatic int wd_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping to the lowest set request if none is found above.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            found,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   index
);

  logic          found_hi;
  logic          found_lo;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;

  // Two priority scans (at/above ptr, and from zero) replace a modular walk.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i] && (PW'(i) >= ptr) && !found_hi) begin
        found_hi = 1'b1;
        hi_idx   = PW'(i);
      end
      if (req[i] && !found_lo) begin
        found_lo = 1'b1;
        lo_idx   = PW'(i);
      end
    end
    found  = found_hi | found_lo;
    index  = found_hi ? hi_idx : lo_idx;
    onehot = '0;
    if (found) onehot[index] = 1'b1;
  end

endmodule

// File: rtl/fpmult_arbiter.sv
// Shares one fpmult multiplier among NREQ requesters, round-robin,
// with a watchdog that aborts an op whose done never arrives.
module fpmult_arbiter
  import fpmult_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [FP_W*NREQ-1:0] dataa,
  input  logic [FP_W*NREQ-1:0] datab,
  output logic [NREQ-1:0]      grant,
  output logic [FP_W-1:0]      result,
  output logic [NREQ-1:0]      valid,
  output logic                 err,
  output logic                 busy,
  output logic                 mult_reset,
  output logic [FP_W-1:0]      mult_dataa,
  output logic [FP_W-1:0]      mult_datab,
  input  logic [FP_W-1:0]      mult_result,
  input  logic                 mult_done
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WD_W = wd_width(TIMEOUT);

  state_t          state;
  state_t          state_n;
  logic            take;
  logic            finish;
  logic            tmo;
  logic            win_found;
  logic [NREQ-1:0] win_oh;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] owner;
  logic [WD_W-1:0] wd;
  logic [FP_W-1:0] sel_a;
  logic [FP_W-1:0] sel_b;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .found  (win_found),
    .onehot (win_oh),
    .index  (win_idx)
  );

  // Select the winning requester's operand pair.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        sel_a = dataa[i*FP_W +: FP_W];
        sel_b = datab[i*FP_W +: FP_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and per-edge decisions; done is ignored in RECOVER.
  always_comb begin
    state_n = state;
    take    = 1'b0;
    finish  = 1'b0;
    tmo     = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          take    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (mult_done) begin
          finish  = 1'b1;
          state_n = RECOVER;
        end else if (wd == WD_W'(TIMEOUT)) begin
          finish  = 1'b1;
          tmo     = 1'b1;
          state_n = RECOVER;
        end
      end
      RECOVER: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand/owner/pointer/watchdog registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      owner      <= '0;
      wd         <= '0;
      grant      <= '0;
      valid      <= '0;
      err        <= 1'b0;
      result     <= '0;
      busy       <= 1'b0;
      mult_reset <= 1'b1;
      mult_dataa <= '0;
      mult_datab <= '0;
    end else begin
      grant      <= take ? win_oh : '0;
      valid      <= finish ? owner : '0;
      err        <= finish & tmo;
      busy       <= (state_n != IDLE);
      mult_reset <= (state_n != RUN);
      if (take) begin
        mult_dataa <= sel_a;
        mult_datab <= sel_b;
        owner      <= win_oh;
        ptr        <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        wd         <= '0;
      end else if (state == RUN && !finish) begin
        wd <= wd + 1'b1;
      end
      if (finish) result <= tmo ? '0 : mult_result;
    end
  end

endmodule

// File: tb/tb_fpmult_arbiter.sv
// Self-checking bench for fpmult_arbiter with a behavioural fpmult model.
module tb_fpmult_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   dataa;
  logic [32*NREQ-1:0]   datab;
  logic [NREQ-1:0]      grant;
  logic [31:0]          result;
  logic [NREQ-1:0]      valid;
  logic                 err;
  logic                 busy;
  logic                 mult_reset;
  logic [31:0]          mult_dataa;
  logic [31:0]          mult_datab;
  logic [31:0]          mult_result;
  logic                 mult_done;

  int          checks   = 0;
  int          failures = 0;
  bit          hang     = 1'b0;
  int          m_cnt;
  logic        m_done;
  int          ptr_m    = 0;
  logic [31:0] last_res;
  int          last_lat;
  int          last_w;

  always #5 clk = ~clk;

  fpmult_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .dataa       (dataa),
    .datab       (datab),
    .grant       (grant),
    .result      (result),
    .valid       (valid),
    .err         (err),
    .busy        (busy),
    .mult_reset  (mult_reset),
    .mult_dataa  (mult_dataa),
    .mult_datab  (mult_datab),
    .mult_result (mult_result),
    .mult_done   (mult_done)
  );

  // 0 normal, 1 zero operand, 2 underflow, 3 overflow
  function automatic int op_class(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e;
    logic [47:0] m;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0) return 1;
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = ea + eb - 127 + (m[47] ? 1 : 0);
    if (e >= 255) return 3;
    if (e <= 0) return 2;
    return 0;
  endfunction

  function automatic int lat_of(input int cls);
    case (cls)
      1: return 1;
      2: return 2;
      3: return 3;
      default: return 6;
    endcase
  endfunction

  // Truncating single-precision product, good enough as a reference multiplier.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int e;
    logic [47:0] m;
    logic [22:0] frac;
    s = a[31] ^ b[31];
    case (op_class(a, b))
      1, 2: return {s, 31'b0};
      3: return {s, 8'hFF, 23'b0};
      default: begin
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
          e = e + 1;
          frac = m[46:24];
        end else begin
          frac = m[45:23];
        end
        return {s, e[7:0], frac};
      end
    endcase
  endfunction

  function automatic int rr_ref(input logic [NREQ-1:0] mask, input int p);
    for (int k = 0; k < NREQ; k++)
      if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic int gidx(input logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Multiplier model: done rises L cycles after its reset is released.
  assign mult_result = fmul(mult_dataa, mult_datab);
  assign mult_done   = m_done;
  always @(posedge clk) begin
    if (mult_reset) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (!hang && (m_cnt + 1 >= lat_of(op_class(mult_dataa, mult_datab))))
        m_done <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
    dataa[r*32 +: 32] = a;
    datab[r*32 +: 32] = b;
  endtask

  task automatic rand_pair(input int cls, output logic [31:0] a, output logic [31:0] b);
    case (cls)
      1: begin
        a = {1'($urandom), 31'b0};
        b = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      end
      2: begin
        a = {1'($urandom), 8'($urandom_range(1, 50)), 23'($urandom)};
        b = {1'($urandom), 8'($urandom_range(1, 50)), 23'($urandom)};
      end
      3: begin
        a = {1'($urandom), 8'($urandom_range(200, 254)), 23'($urandom)};
        b = {1'($urandom), 8'($urandom_range(200, 254)), 23'($urandom)};
      end
      default: begin
        a = {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
        b = {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
      end
    endcase
  endtask

  task automatic do_op(input logic [NREQ-1:0] mask, input bit to);
    int w, n, el;
    logic [31:0] a, b, er;
    w = rr_ref(mask, ptr_m);
    a = dataa[w*32 +: 32];
    b = datab[w*32 +: 32];
    req = mask;
    n = 0;
    do begin tick(); n++; end while (grant == '0 && n < 30);
    chk("grant", 32'(grant), 32'(oh(w)));
    if (grant == '0) begin
      req = '0;
      return;
    end
    chk("op_a_latched", mult_dataa, a);
    chk("op_b_latched", mult_datab, b);
    chk("busy_run", 32'(busy), 32'd1);
    chk("mult_reset_run", 32'(mult_reset), 32'd0);
    ptr_m = (w + 1) % NREQ;
    req   = '0;
    dataa = {$urandom, $urandom, $urandom, $urandom};
    datab = {$urandom, $urandom, $urandom, $urandom};
    if (to) begin
      er = 32'h0;
      el = TIMEOUT + 1;
    end else begin
      er = fmul(a, b);
      el = lat_of(op_class(a, b)) + 1;
    end
    n = 0;
    do begin tick(); n++; end while (valid == '0 && n < 40);
    chk("latency", 32'(n), 32'(el));
    chk("valid_owner", 32'(valid), 32'(oh(w)));
    chk("result", result, er);
    chk("err", 32'(err), 32'(to));
    chk("op_a_stable", mult_dataa, a);
    chk("mult_reset_recover", 32'(mult_reset), 32'd1);
    last_res = result;
    last_lat = n;
    last_w   = w;
    tick();
    chk("valid_one_cycle", 32'(valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int n, got, gi, owner, last_t, nval;
    int ord[5] = '{0, 1, 2, 3, 0};
    logic [31:0] a, b;
    logic [31:0] fa[NREQ];
    logic [31:0] fb[NREQ];

    reset = 1'b0;
    req   = '0;
    dataa = '0;
    datab = '0;
    #1 reset = 1'b1;
    tick(); tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mult_reset", 32'(mult_reset), 32'd1);
    chk("rst_mult_dataa", mult_dataa, 32'd0);
    chk("rst_mult_datab", mult_datab, 32'd0);
    reset = 1'b0;
    tick();

    // Directed plan cases
    set_op(1, 32'h40000000, 32'h40400000);
    do_op(4'b0010, 1'b0);
    chk("single_lat", 32'(last_lat), 32'd7);
    chk("single_res", last_res, 32'h40C00000);

    set_op(2, 32'h80000000, 32'h3F800000);
    do_op(4'b0100, 1'b0);
    chk("zero_lat", 32'(last_lat), 32'd2);
    chk("zero_res", last_res, 32'h80000000);

    set_op(0, 32'h00800000, 32'h00800000);
    do_op(4'b0001, 1'b0);
    chk("uflow_lat", 32'(last_lat), 32'd3);
    chk("uflow_res", last_res, 32'h00000000);

    set_op(3, 32'h7F000000, 32'h7F000000);
    do_op(4'b1000, 1'b0);
    chk("oflow_lat", 32'(last_lat), 32'd4);
    chk("oflow_res", last_res, 32'h7F800000);

    // Fairness under continuous demand
    for (int r = 0; r < NREQ; r++) begin
      rand_pair(0, a, b);
      fa[r] = a;
      fb[r] = b;
      set_op(r, a, b);
    end
    req = '1;
    got = 0; n = 0; last_t = 0; owner = 0; nval = 0;
    while (got < 5 && n < 80) begin
      tick(); n++;
      if (valid != '0) begin
        nval++;
        chk("fair_valid", 32'(valid), 32'(oh(owner)));
        chk("fair_result", result, fmul(fa[owner], fb[owner]));
      end
      if (grant != '0) begin
        gi = gidx(grant);
        chk("fair_order", 32'(gi), 32'(ord[got]));
        if (got > 0) chk("fair_spacing", 32'(n - last_t), 32'd9);
        last_t = n;
        owner  = gi;
        ptr_m  = (gi + 1) % NREQ;
        got++;
        if (got == 5) req = '0;
      end
    end
    chk("fair_grants", 32'(got), 32'd5);
    n = 0;
    do begin tick(); n++; end while (valid == '0 && n < 20);
    chk("fair_last_valid", 32'(valid), 32'(oh(owner)));
    nval++;
    chk("fair_valid_count", 32'(nval), 32'd5);
    tick();

    // Watchdog
    hang = 1'b1;
    rand_pair(0, a, b);
    set_op(2, a, b);
    do_op(4'b0100, 1'b1);
    chk("wd_lat", 32'(last_lat), 32'(TIMEOUT + 1));
    chk("wd_res", last_res, 32'd0);
    hang = 1'b0;
    rand_pair(0, a, b);
    set_op(3, a, b);
    do_op(4'b1000, 1'b0);
    chk("wd_next_lat", 32'(last_lat), 32'd7);

    // Reset in the middle of RUN
    rand_pair(0, a, b);
    set_op(1, a, b);
    req = 4'b0010;
    n = 0;
    do begin tick(); n++; end while (grant == '0 && n < 30);
    chk("mid_grant", 32'(grant), 32'(oh(1)));
    req = '0;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("mid_mult_reset", 32'(mult_reset), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_valid", 32'(valid), 32'd0);
    tick(); tick();
    reset = 1'b0;
    ptr_m = 0;
    nval = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (valid != '0) nval++;
    end
    chk("mid_no_valid", 32'(nval), 32'd0);
    rand_pair(0, a, b); set_op(1, a, b);
    rand_pair(0, a, b); set_op(2, a, b);
    do_op(4'b0110, 1'b0);
    chk("mid_ptr_zero", 32'(last_w), 32'd1);
    rand_pair(0, a, b); set_op(2, a, b);
    do_op(4'b0100, 1'b0);
    chk("mid_req2", 32'(last_w), 32'd2);

    // Randomized masks and operand classes
    for (int t = 0; t < 12; t++) begin
      for (int r = 0; r < NREQ; r++) begin
        rand_pair(int'($urandom_range(0, 3)), a, b);
        set_op(r, a, b);
      end
      do_op(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
